// File: rtl/arb_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arb_chan_fifo
// Description : Per-channel output buffer in front of the arbitter. Event
//               words are written into a circular RAM. Only whole committed
//               blocks are offered on a req/ack word handshake. A block that
//               would overflow the RAM is dropped as a unit.
//               Optional dropped-block counter: define ARB_CHAN_FIFO_OVFCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_chan_fifo #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_en,
    input  logic          wr_commit,
    input  logic          wr_abort,
    output logic [DW-1:0] data,
    output logic          req,
    input  logic          ack,
    output logic [AW:0]   words,
    output logic [15:0]   ovf_cnt
);

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_OVF   = 2'd2
    } wstate_t;

    wstate_t       state_q;
    logic [AW-1:0] waddr_q;
    logic [AW-1:0] caddr_q;
    logic [AW-1:0] raddr_q;
    logic [AW-1:0] raddr_d;
    logic [DW-1:0] data_q;
    logic          req_q;
    logic          full;
    logic          do_write;
    logic          consume;

    logic [DW-1:0] mem [0:(2**AW)-1];

    // One slot is always kept empty so that waddr==raddr means "empty".
    assign full    = ((waddr_q + ONE) == raddr_q);
    assign consume = ack && req_q;
    assign raddr_d = consume ? (raddr_q + ONE) : raddr_q;

    // Decide whether the incoming word lands in the RAM this cycle.
    always_comb begin
        do_write = 1'b0;
        case (state_q)
            ST_IDLE:  do_write = wr_en && !full;
            ST_WRITE: do_write = wr_en && !full && !wr_abort;
            default:  do_write = 1'b0;
        endcase
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[waddr_q] <= wr_data;
        end
    end

    // Write-side FSM: block assembly, commit, abort and overflow drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            waddr_q <= '0;
            caddr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Commit/abort with no open block are no-ops.
                    if (wr_en) begin
                        if (full) begin
                            state_q <= ST_OVF;
                        end else begin
                            waddr_q <= waddr_q + ONE;
                            state_q <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_abort) begin
                        waddr_q <= caddr_q;
                        state_q <= ST_IDLE;
                    end else if (wr_commit) begin
                        if (wr_en && full) begin
                            // Closing word does not fit: the block is dropped.
                            waddr_q <= caddr_q;
                        end else if (wr_en) begin
                            waddr_q <= waddr_q + ONE;
                            caddr_q <= waddr_q + ONE;
                        end else begin
                            caddr_q <= waddr_q;
                        end
                        state_q <= ST_IDLE;
                    end else if (wr_en) begin
                        if (full) begin
                            state_q <= ST_OVF;
                        end else begin
                            waddr_q <= waddr_q + ONE;
                        end
                    end
                end
                ST_OVF: begin
                    // Swallow the rest of the block until it is closed.
                    if (wr_commit || wr_abort) begin
                        waddr_q <= caddr_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Read side: prefetch the next word on ack so back-to-back acks see no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raddr_q <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            raddr_q <= raddr_d;
            req_q   <= (caddr_q != raddr_d);
            data_q  <= mem[raddr_d];
        end
    end

    assign data  = data_q;
    assign req   = req_q;
    assign words = {1'b0, caddr_q - raddr_q};

`ifdef ARB_CHAN_FIFO_OVFCNT_EN
    logic        drop_blk;
    logic [15:0] ovf_q;

    assign drop_blk = ((state_q == ST_OVF) && (wr_commit || wr_abort)) ||
                      ((state_q == ST_WRITE) && !wr_abort && wr_commit && wr_en && full);

    // Saturating count of dropped blocks, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else if (drop_blk && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_q;
`else
    assign ovf_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arb_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_chan_fifo
// Description : Scoreboard bench for arb_chan_fifo. The driver keeps a
//               block-level model (open block, committed word queue) and
//               pushes committed words; a monitor on the falling edge pops
//               them on every handshake and checks req/words/ovf_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_chan_fifo;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        wr_commit;
    logic        wr_abort;
    logic [15:0] data;
    logic        req;
    logic        ack;
    logic [11:0] words;
    logic [15:0] ovf_cnt;

    // Model state shared between driver and monitor
    logic [15:0] exp_q[$];
    logic [15:0] blk[$];
    bit          ovf_st;
    int          ovf_model;
    int          tot_commit;
    int          tot_pop;
    int          total;
    int          bad;

    arb_chan_fifo #(.AW(11), .DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .wr_commit (wr_commit),
        .wr_abort  (wr_abort),
        .data      (data),
        .req       (req),
        .ack       (ack),
        .words     (words),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endfunction

    // Drive one cycle of inputs and advance the block-level model.
    task automatic cycle(input bit en, input logic [15:0] d, input bit cm,
                         input bit ab, input bit ak, input bit rn = 1'b1);
        int occ;
        @(posedge clk);
        #1;
        wr_en     = en;
        wr_data   = d;
        wr_commit = cm;
        wr_abort  = ab;
        ack       = ak;
        rst_n     = rn;
        if (!rn) begin
            exp_q.delete();
            blk.delete();
            ovf_st     = 1'b0;
            ovf_model  = 0;
            tot_commit = 0;
        end else begin
            occ = exp_q.size() + blk.size();
            if (ovf_st) begin
                if (cm || ab) begin
                    blk.delete();
                    ovf_st = 1'b0;
                    if (ovf_model != 16'hFFFF) ovf_model++;
                end
            end else if (ab) begin
                blk.delete();
            end else begin
                if (en) begin
                    if (occ == DEPTH - 1) ovf_st = 1'b1;
                    else blk.push_back(d);
                end
                if (cm && !ovf_st) begin
                    foreach (blk[i]) exp_q.push_back(blk[i]);
                    tot_commit += blk.size();
                    blk.delete();
                end
            end
        end
    endtask

    // Hold ack until every committed word has been delivered.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: checks outputs of the last edge, pops on handshakes, predicts the next edge.
    initial begin
        bit          have;
        bit          p_req;
        int          p_words;
        int          p_ovf;
        int          prev_c;
        logic [15:0] w;
        have = 1'b0; p_req = 1'b0; p_words = 0; p_ovf = 0; prev_c = 0;
        forever begin
            @(negedge clk);
            if (have) begin
                chk("req", int'(req), int'(p_req));
                chk("words", int'(words), p_words);
                chk("ovf_cnt", int'(ovf_cnt), p_ovf);
            end
            if (!rst_n) begin
                tot_pop = 0; prev_c = 0;
                p_req = 1'b0; p_words = 0; p_ovf = 0;
                have = 1'b1;
            end else if (have) begin
                if (ack && p_req) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL data: handshake with empty scoreboard, got %0h at %0t", data, $time);
                    end else begin
                        w = exp_q.pop_front();
                        chk("data", int'(data), int'(w));
                    end
                    tot_pop++;
                end
                p_req   = (prev_c != tot_pop);
                p_words = tot_commit - tot_pop;
                prev_c  = tot_commit;
`ifdef ARB_CHAN_FIFO_OVFCNT_EN
                p_ovf   = ovf_model;
`else
                p_ovf   = 0;
`endif
            end
        end
    end

    // Stimulus
    initial begin
        bit          en, cm, ab, ak;
        int          occ;
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_commit = 1'b0; wr_abort = 1'b0; ack = 1'b0;
        total = 0; bad = 0; tot_commit = 0; tot_pop = 0; ovf_model = 0; ovf_st = 1'b0;
        cycle(0, 16'h0, 0, 0, 0, 0);
        cycle(0, 16'h0, 0, 0, 0, 0);
        cycle(0, 16'h0, 0, 0, 0);

        // Ten words 0..9, committed, then streamed out with ack held
        for (int i = 0; i < 10; i++) cycle(1, 16'(i), 0, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);
        cycle(0, 16'h0, 0, 0, 0);
        drain(20);

        // Aborted block vanishes; following A,B,C block is all that is read
        for (int i = 0; i < 5; i++) cycle(1, 16'h100 + 16'(i), 0, 0, 0);
        cycle(0, 16'h0, 0, 1, 0);
        cycle(0, 16'h0, 0, 0, 0);
        cycle(1, 16'h000A, 0, 0, 0);
        cycle(1, 16'h000B, 0, 0, 0);
        cycle(1, 16'h000C, 1, 0, 0);
        drain(20);

        // Move pointers to 2040, then a 16-word block straddling the wrap
        for (int i = 0; i < 2027; i++) cycle(1, 16'($urandom), 0, 0, 1);
        cycle(0, 16'h0, 1, 0, 1);
        drain(2100);
        for (int i = 0; i < 16; i++) cycle(1, 16'h5000 + 16'(i), 0, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);
        cycle(0, 16'h0, 0, 0, 0);
        drain(40);

        // Fill to 2047 words, then a 1-word block that must be dropped
        for (int i = 0; i < 2047; i++) cycle(1, 16'($urandom), 0, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);
        cycle(1, 16'hDEAD, 0, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 16'h0, 0, 0, 0);
        drain(2100);

        // Commit of a 2-word block in the same cycle as an ack, 4 words pending
        for (int i = 0; i < 4; i++) cycle(1, 16'h7000 + 16'(i), 0, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);
        cycle(0, 16'h0, 0, 0, 0);
        cycle(1, 16'h7100, 0, 0, 0);
        cycle(1, 16'h7101, 0, 0, 0);
        cycle(0, 16'h0, 1, 0, 1);
        cycle(0, 16'h0, 0, 0, 0);
        drain(20);

        // Reset in the middle of both a block and a read
        for (int i = 0; i < 6; i++) cycle(1, 16'h8000 + 16'(i), 0, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);
        cycle(0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 16'h8100 + 16'(i), 0, 0, 1);
        cycle(0, 16'h0, 0, 0, 1, 0);
        cycle(0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 16'h9000 + 16'(i), 0, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);
        drain(20);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 99) < 60);
            cm = ($urandom_range(0, 99) < 10);
            ab = ($urandom_range(0, 99) < 3);
            ak = ($urandom_range(0, 99) < 50);
            if (ab) en = 1'b0;
            occ = exp_q.size() + blk.size();
            if (en && cm && (blk.size() == 0 || ovf_st || occ >= DEPTH - 1)) cm = 1'b0;
            cycle(en, 16'($urandom), cm, ab, ak);
        end
        cycle(0, 16'h0, 0, 1, 0);
        drain(5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
